// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer between the I-cache (m0) and D-cache (m1)
// line paths and the single-ported Memory, with a per-transaction watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [LINE_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [LINE_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [LINE_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [LINE_W-1:0] m1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [LINE_W-1:0] mem_wr_data,
    input  logic              mem_rd_data_valid,
    input  logic              mem_wr_data_ready,
    input  logic [LINE_W-1:0] mem_rd_data
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_RD = 2'd1,
        BUSY_WR = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_r;
    logic              last_grant_r;
    logic              gnt_r;
    logic [WD_W-1:0]   wd_r;

    logic              grant_sel_s;
    logic              req_any_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [LINE_W-1:0] sel_wdata_s;

    // Pick the master to grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_sel_s = 1'b0;
        if (m0_req && m1_req) begin
            grant_sel_s = ~last_grant_r;
        end else if (m1_req) begin
            grant_sel_s = 1'b1;
        end else begin
            grant_sel_s = 1'b0;
        end
    end

    assign req_any_s   = m0_req | m1_req;
    assign sel_we_s    = grant_sel_s ? m1_we    : m0_we;
    assign sel_addr_s  = grant_sel_s ? m1_addr  : m0_addr;
    assign sel_wdata_s = grant_sel_s ? m1_wdata : m0_wdata;

    // Transaction sequencer: grant, hold the strobe, ack on response or watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            gnt_r        <= 1'b0;
            wd_r         <= {WD_W{1'b0}};
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_rd_addr  <= {ADDR_W{1'b0}};
            mem_wr_addr  <= {ADDR_W{1'b0}};
            mem_wr_data  <= {LINE_W{1'b0}};
            m0_ack       <= 1'b0;
            m0_err       <= 1'b0;
            m0_rdata     <= {LINE_W{1'b0}};
            m1_ack       <= 1'b0;
            m1_err       <= 1'b0;
            m1_rdata     <= {LINE_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_any_s) begin
                        gnt_r        <= grant_sel_s;
                        last_grant_r <= grant_sel_s;
                        wd_r         <= {WD_W{1'b0}};
                        if (sel_we_s) begin
                            mem_write   <= 1'b1;
                            mem_wr_addr <= sel_addr_s;
                            mem_wr_data <= sel_wdata_s;
                            state_r     <= BUSY_WR;
                        end else begin
                            mem_read    <= 1'b1;
                            mem_rd_addr <= sel_addr_s;
                            state_r     <= BUSY_RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_RD: begin
                    // A response in the watchdog's last cycle still completes normally.
                    if (mem_rd_data_valid) begin
                        mem_read <= 1'b0;
                        state_r  <= DONE;
                        if (gnt_r) begin
                            m1_ack   <= 1'b1;
                            m1_err   <= 1'b0;
                            m1_rdata <= mem_rd_data;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_err   <= 1'b0;
                            m0_rdata <= mem_rd_data;
                        end
                    end else if (wd_r == WD_LAST) begin
                        mem_read <= 1'b0;
                        state_r  <= DONE;
                        if (gnt_r) begin
                            m1_ack <= 1'b1;
                            m1_err <= 1'b1;
                        end else begin
                            m0_ack <= 1'b1;
                            m0_err <= 1'b1;
                        end
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                BUSY_WR: begin
                    if (mem_wr_data_ready) begin
                        mem_write <= 1'b0;
                        state_r   <= DONE;
                        if (gnt_r) begin
                            m1_ack <= 1'b1;
                            m1_err <= 1'b0;
                        end else begin
                            m0_ack <= 1'b1;
                            m0_err <= 1'b0;
                        end
                    end else if (wd_r == WD_LAST) begin
                        mem_write <= 1'b0;
                        state_r   <= DONE;
                        if (gnt_r) begin
                            m1_ack <= 1'b1;
                            m1_err <= 1'b1;
                        end else begin
                            m0_ack <= 1'b1;
                            m0_err <= 1'b1;
                        end
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                DONE: begin
                    // Memory flags lag the strobe by an edge; they are deliberately ignored here.
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    m0_ack    <= 1'b0;
                    m1_ack    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand sequences for contention and reset during a busy read.
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = 32'h0;
    logic [LINE_W-1:0] m0_wdata = 128'h0;
    logic              m0_ack, m0_err;
    logic [LINE_W-1:0] m0_rdata;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m1_addr = 32'h0;
    logic [LINE_W-1:0] m1_wdata = 128'h0;
    logic              m1_ack, m1_err;
    logic [LINE_W-1:0] m1_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
    logic [LINE_W-1:0] mem_wr_data;
    logic              mem_rd_data_valid = 1'b0;
    logic              mem_wr_data_ready = 1'b0;
    logic [LINE_W-1:0] mem_rd_data = 128'h0;

    int   vectors = 0;
    int   errors  = 0;
    logic mute = 1'b0;
    logic excl_bad = 1'b0;
    logic [LINE_W-1:0] store [16];
    logic [15:0]       wr_ok = 16'h0;

    localparam logic [LINE_W-1:0] DB = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    localparam logic [LINE_W-1:0] XD = 128'h5555AAAA_12345678_9ABCDEF0_0F0FF0F0;

    typedef struct {
        int                m;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic              mute;
        logic [LINE_W-1:0] exp_rdata;
        logic              exp_err;
        int                exp_lat;
        int                exp_strobe;
    } vec_t;

    vec_t vt [12];

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data_valid(mem_rd_data_valid), .mem_wr_data_ready(mem_wr_data_ready),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Default line content for never-written lines.
    function automatic logic [LINE_W-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {w, w, w, w};
    endfunction

    // Memory read port: valid registered on posedge, one edge behind the strobe.
    always @(posedge clk) begin
        if (mem_read === 1'b1 && !mute) begin
            mem_rd_data_valid <= 1'b1;
            mem_rd_data <= wr_ok[mem_rd_addr[7:4]] ? store[mem_rd_addr[7:4]] : pat(int'(mem_rd_addr[7:4]));
        end else begin
            mem_rd_data_valid <= 1'b0;
        end
    end

    // Memory write port: done flag registered on negedge.
    always @(negedge clk) begin
        if (mem_write === 1'b1 && !mute) begin
            mem_wr_data_ready        <= 1'b1;
            store[mem_wr_addr[7:4]]  <= mem_wr_data;
            wr_ok[mem_wr_addr[7:4]]  <= 1'b1;
        end else begin
            mem_wr_data_ready <= 1'b0;
        end
    end

    // Sticky flag for both strobes or both acks high together.
    always @(negedge clk) begin
        if (!rst && ((mem_read === 1'b1 && mem_write === 1'b1) || (m0_ack === 1'b1 && m1_ack === 1'b1)))
            excl_bad <= 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output int who, output int lat);
        who = -1;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (m0_ack === 1'b1) begin
                who = 0; lat = n; break;
            end else if (m1_ack === 1'b1) begin
                who = 1; lat = n; break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        int   strobe;
        logic other;
        logic err_s;
        logic [LINE_W-1:0] rd_s;
        mute = v.mute;
        if (v.m == 0) begin
            m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_req = 1'b1;
        end else begin
            m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_req = 1'b1;
        end
        lat = -1; strobe = 0; other = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if ((v.we ? mem_write : mem_read) === 1'b1) strobe++;
            if (((v.m == 0) ? m1_ack : m0_ack) === 1'b1) other = 1'b1;
            if (((v.m == 0) ? m0_ack : m1_ack) === 1'b1) begin
                lat = n; break;
            end
        end
        err_s = (v.m == 0) ? m0_err : m1_err;
        rd_s  = (v.m == 0) ? m0_rdata : m1_rdata;
        m0_req = 1'b0; m1_req = 1'b0; mute = 1'b0;
        check($sformatf("v%0d_latency", idx), 128'(lat), 128'(v.exp_lat));
        check($sformatf("v%0d_strobe_cycles", idx), 128'(strobe), 128'(v.exp_strobe));
        check($sformatf("v%0d_err", idx), 128'(err_s), 128'(v.exp_err));
        check($sformatf("v%0d_rdata", idx), rd_s, v.exp_rdata);
        check($sformatf("v%0d_other_ack", idx), 128'(other), 128'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_ack_pulse", idx), 128'(m0_ack | m1_ack), 128'd0);
    endtask

    initial begin
        int who;
        int lat;
        vt[0]  = '{0, 1'b0, 32'h10, 128'h0, 1'b0, pat(1), 1'b0, 2, 2};
        vt[1]  = '{1, 1'b1, 32'h20, DB,     1'b0, 128'h0, 1'b0, 1, 1};
        vt[2]  = '{0, 1'b0, 32'h20, 128'h0, 1'b0, DB,     1'b0, 2, 2};
        vt[3]  = '{0, 1'b0, 32'h10, 128'h0, 1'b0, pat(1), 1'b0, 2, 2};
        vt[4]  = '{0, 1'b0, 32'h30, 128'h0, 1'b0, pat(3), 1'b0, 2, 2};
        vt[5]  = '{1, 1'b0, 32'h40, 128'h0, 1'b0, pat(4), 1'b0, 2, 2};
        vt[6]  = '{0, 1'b1, 32'hF0, XD,     1'b0, pat(3), 1'b0, 1, 1};
        vt[7]  = '{1, 1'b0, 32'hF0, 128'h0, 1'b0, XD,     1'b0, 2, 2};
        vt[8]  = '{0, 1'b0, 32'h50, 128'h0, 1'b1, pat(3), 1'b1, 8, 8};
        vt[9]  = '{0, 1'b0, 32'h50, 128'h0, 1'b0, pat(5), 1'b0, 2, 2};
        vt[10] = '{1, 1'b1, 32'h60, 128'h1, 1'b1, XD,     1'b1, 8, 8};
        vt[11] = '{1, 1'b0, 32'h20, 128'h0, 1'b0, DB,     1'b0, 2, 2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_m0_ack",      128'(m0_ack),    128'd0);
        check("rst_m1_ack",      128'(m1_ack),    128'd0);
        check("rst_m0_err",      128'(m0_err),    128'd0);
        check("rst_m1_err",      128'(m1_err),    128'd0);
        check("rst_mem_read",    128'(mem_read),  128'd0);
        check("rst_mem_write",   128'(mem_write), 128'd0);
        check("rst_mem_rd_addr", 128'(mem_rd_addr), 128'd0);
        check("rst_mem_wr_addr", 128'(mem_wr_addr), 128'd0);
        check("rst_mem_wr_data", mem_wr_data, 128'd0);
        check("rst_m0_rdata",    m0_rdata,    128'd0);
        check("rst_m1_rdata",    m1_rdata,    128'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        // Both masters hold read requests: last grant was m1, so m0, m1, m0, m1.
        m0_we = 1'b0; m0_addr = 32'h10; m1_we = 1'b0; m1_addr = 32'h40;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(who, lat);
            check($sformatf("rr_grant%0d", k), 128'(who), 128'(k % 2));
            check($sformatf("rr_rdata%0d", k), (who == 1) ? m1_rdata : m0_rdata,
                  (k % 2 == 1) ? pat(4) : pat(1));
            if (k == 3) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset while m0's read is in flight; last_grant returns to 1 so m0 wins the tie.
        m0_we = 1'b0; m0_addr = 32'h10; m0_req = 1'b1;
        @(posedge clk); #1;
        check("rstseq_busy_read", 128'(mem_read), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstseq_read_dropped", 128'(mem_read), 128'd0);
        check("rstseq_no_ack", 128'(m0_ack | m1_ack), 128'd0);
        m1_we = 1'b0; m1_addr = 32'h40; m1_req = 1'b1;
        rst = 1'b0;
        wait_ack(who, lat);
        check("rstseq_first_grant", 128'(who), 128'd0);
        check("rstseq_first_latency", 128'(lat), 128'd2);
        check("rstseq_m0_rdata", m0_rdata, pat(1));
        m0_req = 1'b0;
        wait_ack(who, lat);
        check("rstseq_second_grant", 128'(who), 128'd1);
        check("rstseq_m1_rdata", m1_rdata, pat(4));
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check("exclusive_strobe_ack", 128'(excl_bad), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
